// File: rtl/seq_det_pkg.sv
// Shared types, defaults and helpers for the programmable sequence detector.
// Optional hit counters are enabled with SEQDET_HIT_CNT_EN.
package seq_det_pkg;

  typedef enum logic {
    NON_OVL = 1'b0,
    OVL     = 1'b1
  } mode_e;

  localparam int DEF_LEN = 4;

  // Element 0 is the rightmost nibble.
  localparam logic [3:0][3:0] DEF_PAT = {
    4'b0110, 4'b1001, 4'b1010, 4'b1101
  };

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [3:0] def_pat(input int k);
    logic [1:0] sel;
    sel = k[1:0];
    return (k < 4 && k >= 0) ? DEF_PAT[sel] : 4'b0000;
  endfunction

  function automatic int eff_len(input int len, input int max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/seq_det_if.sv
// Pattern-table write bus shared by the detector slots.
// Optional hit counters are enabled with SEQDET_HIT_CNT_EN.
interface seq_det_if
  import seq_det_pkg::*;
#(
  parameter int NUM_PAT = 4,
  parameter int PAT_LEN = 4
);
  localparam int IDX_W = idx_w(NUM_PAT);
  localparam int LEN_W = $clog2(PAT_LEN + 1);

  logic             we;
  logic [IDX_W-1:0] idx;
  logic [PAT_LEN-1:0] pat;
  logic [LEN_W-1:0] len;

  modport master (output we, idx, pat, len);
  modport slave  (input  we, idx, pat, len);
endinterface

// File: rtl/seq_det_slot.sv
// One pattern slot: table register plus masked window compare.
// Optional hit counters are enabled with SEQDET_HIT_CNT_EN.
module seq_det_slot
  import seq_det_pkg::*;
#(
  parameter int PAT_LEN = 4,
  parameter int K       = 0
) (
  input  logic clock_i,
  input  logic reset_i,
  seq_det_if.slave cfg,
  input  logic valid,
  input  logic [PAT_LEN-1:0] win,
  input  logic [$clog2(PAT_LEN)-1:0] fill,
  output logic match
);
  localparam int LEN_W = $clog2(PAT_LEN + 1);
  localparam bit HAS_DEF = (PAT_LEN >= 4) && (K < 4);

  localparam logic [PAT_LEN-1:0] RST_PAT =
    HAS_DEF ? PAT_LEN'(def_pat(K)) : '0;
  localparam logic [LEN_W-1:0] RST_LEN =
    HAS_DEF ? LEN_W'(DEF_LEN) : '0;

  logic [PAT_LEN-1:0] pat_q;
  logic [LEN_W-1:0]   len_q;
  logic [PAT_LEN-1:0] mask;
  int                 le;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      pat_q <= RST_PAT;
      len_q <= RST_LEN;
    end else if (cfg.we && int'(cfg.idx) == K) begin
      pat_q <= cfg.pat;
      len_q <= cfg.len;
    end
  end

  // Only the low Le bits of the window take part in the compare.
  always_comb begin
    le   = eff_len(int'(len_q), PAT_LEN);
    mask = '0;
    for (int i = 0; i < PAT_LEN; i++)
      if (i < le) mask[i] = 1'b1;
    match = valid && (le >= 2)
         && (int'(fill) >= le - 1)
         && (((win ^ pat_q) & mask) == '0);
  end

endmodule

// File: rtl/seq_det_prog.sv
// Programmable multi-pattern Mealy sequence detector.
// Optional hit counters are enabled with SEQDET_HIT_CNT_EN.
module seq_det_prog
  import seq_det_pkg::*;
#(
  parameter int NUM_PAT = 4,
  parameter int PAT_LEN = 4,
  parameter int CNT_W   = 16,
  localparam int IDX_W  = idx_w(NUM_PAT),
  localparam int LEN_W  = $clog2(PAT_LEN + 1)
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               in_i,
  input  logic               valid_i,
  input  logic               ovl_mode_i,
  input  logic               cfg_we_i,
  input  logic [IDX_W-1:0]   cfg_idx_i,
  input  logic [PAT_LEN-1:0] cfg_pat_i,
  input  logic [LEN_W-1:0]   cfg_len_i,
  output logic [NUM_PAT-1:0] match_o,
  output logic               any_o,
  output logic [IDX_W-1:0]   match_id_o,
  input  logic [IDX_W-1:0]   cnt_idx_i,
  input  logic               cnt_clr_i,
  output logic [CNT_W-1:0]   cnt_o
);
  localparam int FILL_W = $clog2(PAT_LEN);
  localparam logic [FILL_W-1:0] FILL_MAX =
    FILL_W'(PAT_LEN - 1);

  logic [PAT_LEN-2:0] hist_q;
  logic [FILL_W-1:0]  fill_q;
  logic [PAT_LEN-1:0] win;
  logic               cfg_hit;
  mode_e              mode;

  seq_det_if #(.NUM_PAT(NUM_PAT), .PAT_LEN(PAT_LEN)) cfg_if ();

  assign cfg_if.we  = cfg_we_i;
  assign cfg_if.idx = cfg_idx_i;
  assign cfg_if.pat = cfg_pat_i;
  assign cfg_if.len = cfg_len_i;

  assign win     = {hist_q, in_i};
  assign mode    = mode_e'(ovl_mode_i);
  assign cfg_hit = cfg_we_i && (int'(cfg_idx_i) < NUM_PAT);

  for (genvar k = 0; k < NUM_PAT; k++) begin : g_slot
    seq_det_slot #(.PAT_LEN(PAT_LEN), .K(k)) u_slot (
      .clock_i (clock_i),
      .reset_i (reset_i),
      .cfg     (cfg_if),
      .valid   (valid_i),
      .win     (win),
      .fill    (fill_q),
      .match   (match_o[k])
    );
  end

  assign any_o = |match_o;

  always_comb begin
    match_id_o = '0;
    for (int k = NUM_PAT - 1; k >= 0; k--)
      if (match_o[k]) match_id_o = IDX_W'(k);
  end

  // A table write flushes fill so stale history cannot match.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      if (valid_i) hist_q <= win[PAT_LEN-2:0];
      if (cfg_hit)
        fill_q <= '0;
      else if (valid_i) begin
        if (mode == NON_OVL && any_o)
          fill_q <= '0;
        else if (fill_q != FILL_MAX)
          fill_q <= fill_q + 1'b1;
      end
    end
  end

`ifdef SEQDET_HIT_CNT_EN
  logic [CNT_W-1:0] cnt_q [NUM_PAT];

  always_ff @(posedge clock_i) begin
    for (int k = 0; k < NUM_PAT; k++) begin
      if (reset_i || cnt_clr_i)
        cnt_q[k] <= '0;
      else if (match_o[k] && cnt_q[k] != '1)
        cnt_q[k] <= cnt_q[k] + 1'b1;
    end
  end

  assign cnt_o = (int'(cnt_idx_i) < NUM_PAT)
               ? cnt_q[cnt_idx_i] : '0;
`else
  logic unused_cnt;
  assign unused_cnt = ^{cnt_idx_i, cnt_clr_i};
  assign cnt_o      = '0;
`endif

endmodule
